reg_write_scoreboard: RTL and testbench
=======================================

REG_WRITE_SCOREBOARD -- requirements
Module: reg_write_scoreboard

Interface
REQ-001 Parameter DEPTH, default 3, SHALL set the number of in-flight writer stages tracked; stage 0 is execute, stage DEPTH-1 is writeback; legal range 2..8.
REQ-002 Parameter JAL_REG, default 31, SHALL set the link register written by jal.
REQ-003 Parameter SETX_REG, default 30, SHALL set the status register written by setx.
REQ-004 Port clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 Port reset  in  1  SHALL be an asynchronous, active-low reset.
REQ-006 Port instruction  in  32  SHALL carry the instruction leaving decode.
REQ-007 Port issue_valid  in  1  SHALL qualify instruction.
REQ-008 Port stall  in  1  SHALL indicate that decode is held this cycle.
REQ-009 Port flush  in  1  SHALL indicate that the instruction in decode and the one in stage 0 are squashed.
REQ-010 Port md_done  in  1  SHALL be a one-cycle pulse marking completion of the multiply/divide result.
REQ-011 Port src_a, src_b  in  5 each  SHALL carry the decode-stage source register indices.
REQ-012 Port hazard_a, hazard_b  out  1 each  SHALL flag that the source has a pending writer.
REQ-013 Port fwd_a, fwd_b  out  4 each  SHALL give 1 + the index of the youngest matching stage, or 0 for no match.
REQ-014 Port stall_req  out  1  SHALL request that decode be held.
REQ-015 Port md_busy  out  1  SHALL flag an outstanding multiply/divide.

Function
REQ-016 Destination decode SHALL map opcodes as follows: 00000, 00101 and 01000 -> instruction[26:22]; 00011 -> JAL_REG; 10101 -> SETX_REG; all others -> 0.
REQ-017 is_load SHALL be opcode 01000; is_md SHALL be opcode 00000 with instruction[6:2] equal to 00110 or 00111.
REQ-018 Each stage entry SHALL hold {valid, reg[4:0], is_load}.
REQ-019 Every cycle the entries SHALL shift: stage[i] <= stage[i-1] for i>=1, and stage DEPTH-1 retires.
REQ-020 Stage 0 SHALL load the decoded entry when issue_valid && !stall && !flush, with valid = (dest != 0) && !is_md; otherwise stage 0 SHALL load a bubble (valid=0).
REQ-021 When flush is asserted, stage 1 SHALL load a bubble instead of stage 0, squashing the stage-0 instruction.
REQ-022 A match on source s SHALL require s != 0 and a valid stage entry with reg == s.
REQ-023 hazard_x SHALL be high on any stage match, or when md_busy && md_reg == src_x && src_x != 0.
REQ-024 fwd_x SHALL select the lowest-index (youngest) matching stage; an md-only match SHALL give fwd_x = 0 with hazard_x = 1.
REQ-025 stall_req SHALL be high when stage 0 is valid with is_load and its reg matches src_a or src_b (load-use).
REQ-026 stall_req SHALL also be high when md_busy and either source matches md_reg.
REQ-027 stall_req SHALL also be high when md_busy and the decode instruction is a valid is_md.
REQ-028 hazard, fwd and stall_req outputs SHALL be combinational from the current state and inputs, with zero-cycle latency.
REQ-029 An accepted is_md issue SHALL set md_busy=1 and md_reg=dest on the next edge.
REQ-030 md_done while busy SHALL clear md_busy on the next edge; md_done while idle SHALL be ignored.
REQ-031 When md_done coincides with an accepted is_md issue, the new operation SHALL win: md_busy stays 1 and md_reg updates.
REQ-032 flush SHALL NOT clear md_busy.
REQ-033 An is_md issue with dest 0 SHALL set md_busy and SHALL never raise a hazard.

Reset
REQ-034 While reset is low, all stage entries SHALL be invalid, md_busy=0, md_reg=0, and therefore all outputs SHALL be 0, independent of clock.
REQ-035 Reset asserted mid-operation SHALL discard all pending writers and any md operation; md_done after release SHALL be ignored.

Verification
REQ-036 Issue addi r5 (opcode 00101, rd=5), then src_a=5 -> next cycle hazard_a=1, fwd_a=1; one cycle later fwd_a=2; after DEPTH cycles hazard_a=0.
REQ-037 Issue lw r7, then src_b=7 -> stall_req=1 for exactly one cycle, then fwd_b=2 and stall_req=0.
REQ-038 Issue jal, then src_a=31 -> hazard_a=1; issue with dest r0, then src_a=0 -> hazard_a=0.
REQ-039 Issue mul r9, then src_a=9 -> stall_req=1 until the cycle after md_done, then hazard_a=0; md_done together with a new div r4 -> md_busy stays 1, src_a=4 stalls.
REQ-040 Issue lw r3, then flush the next cycle -> stage 1 is invalid and src_a=3 gives hazard_a=0; assert reset with md_busy=1 -> md_busy=0 immediately.

Source files
------------

// File: rtl/reg_write_scoreboard.sv
// Register-write scoreboard: tracks pending destination writes from execute to writeback
// plus one outstanding multiply/divide, and produces hazard, forwarding and stall hints.
module reg_write_scoreboard #(
    parameter int DEPTH    = 3,
    parameter int JAL_REG  = 31,
    parameter int SETX_REG = 30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        issue_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic        md_done,
    input  logic [4:0]  src_a,
    input  logic [4:0]  src_b,
    output logic        hazard_a,
    output logic        hazard_b,
    output logic [3:0]  fwd_a,
    output logic [3:0]  fwd_b,
    output logic        stall_req,
    output logic        md_busy
);

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_LOAD = 5'b01000;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] FN_MUL  = 5'b00110;
    localparam logic [4:0] FN_DIV  = 5'b00111;
    localparam logic [4:0] JAL_R   = 5'(JAL_REG);
    localparam logic [4:0] SETX_R  = 5'(SETX_REG);

    logic [4:0]       opcode;
    logic [4:0]       dec_dest;
    logic             dec_load;
    logic             dec_md;
    logic             accept;
    logic             vld_in;

    logic [DEPTH-1:0] vld_p;
    logic [DEPTH-1:0] ld_p;
    logic [4:0]       reg_p [DEPTH];
    logic [4:0]       md_reg;

    logic [DEPTH-1:0] hit_a;
    logic [DEPTH-1:0] hit_b;
    logic             md_hit_a;
    logic             md_hit_b;
    logic             load_use;

    logic             unused_bits;
    assign unused_bits = ^{instruction[21:7], instruction[1:0]};

    function automatic logic [3:0] youngest(input logic [DEPTH-1:0] hit);
        youngest = 4'd0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hit[i]) youngest = 4'(i + 1);
        end
    endfunction

    // Decode: destination register and writer class of the instruction leaving decode
    always_comb begin
        opcode   = instruction[31:27];
        dec_dest = 5'd0;
        case (opcode)
            OP_ALU, OP_ADDI, OP_LOAD: dec_dest = instruction[26:22];
            OP_JAL:                   dec_dest = JAL_R;
            OP_SETX:                  dec_dest = SETX_R;
            default:                  dec_dest = 5'd0;
        endcase
        dec_load = (opcode == OP_LOAD);
        dec_md   = (opcode == OP_ALU) &&
                   ((instruction[6:2] == FN_MUL) || (instruction[6:2] == FN_DIV));
    end

    assign accept = issue_valid && !stall && !flush;
    // Multiply/divide results are tracked by md_reg, not by the stage pipe.
    assign vld_in = accept && (dec_dest != 5'd0) && !dec_md;

    // Stage pipe control: a flush squashes the instruction now in stage 0 as it moves to stage 1
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p   <= '0;
            md_busy <= 1'b0;
            md_reg  <= 5'd0;
        end else begin
            vld_p <= {vld_p[DEPTH-2:0], vld_in};
            if (flush) vld_p[1] <= 1'b0;
            if (accept && dec_md) begin
                md_busy <= 1'b1;
                md_reg  <= dec_dest;
            end else if (md_done) begin
                md_busy <= 1'b0;
            end
        end
    end

    // Stage pipe payload; only meaningful where the matching valid bit is set
    always_ff @(posedge clock) begin
        reg_p[0] <= dec_dest;
        ld_p     <= {ld_p[DEPTH-2:0], dec_load};
        for (int i = 1; i < DEPTH; i++) begin
            reg_p[i] <= reg_p[i-1];
        end
    end

    // Source matching against every stage and against the outstanding multiply/divide
    always_comb begin
        hit_a = '0;
        hit_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_a[i] = vld_p[i] && (reg_p[i] == src_a) && (src_a != 5'd0);
            hit_b[i] = vld_p[i] && (reg_p[i] == src_b) && (src_b != 5'd0);
        end
    end

    assign md_hit_a = md_busy && (md_reg == src_a) && (src_a != 5'd0);
    assign md_hit_b = md_busy && (md_reg == src_b) && (src_b != 5'd0);
    assign load_use = vld_p[0] && ld_p[0] && (hit_a[0] || hit_b[0]);

    assign hazard_a  = (|hit_a) || md_hit_a;
    assign hazard_b  = (|hit_b) || md_hit_b;
    assign fwd_a     = youngest(hit_a);
    assign fwd_b     = youngest(hit_b);
    // A second multiply/divide must wait until the unit is free.
    assign stall_req = load_use || md_hit_a || md_hit_b || (md_busy && issue_valid && dec_md);

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Self-checking bench: randomized and directed decode traffic, expected outputs from an
// age-based reference model queued per cycle and compared by an independent monitor.
module tb_reg_write_scoreboard;

    localparam int DEPTH    = 3;
    localparam int JAL_REG  = 31;
    localparam int SETX_REG = 30;
    localparam logic [31:0] NOP = 32'hF800_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        issue_valid, stall, flush, md_done;
    logic [4:0]  src_a, src_b;
    logic        hazard_a, hazard_b, stall_req, md_busy;
    logic [3:0]  fwd_a, fwd_b;

    always #5 clock = ~clock;

    reg_write_scoreboard #(.DEPTH(DEPTH), .JAL_REG(JAL_REG), .SETX_REG(SETX_REG)) dut (
        .clock(clock), .reset(reset), .instruction(instruction), .issue_valid(issue_valid),
        .stall(stall), .flush(flush), .md_done(md_done), .src_a(src_a), .src_b(src_b),
        .hazard_a(hazard_a), .hazard_b(hazard_b), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_req(stall_req), .md_busy(md_busy)
    );

    typedef struct { int hz_a; int hz_b; int fa; int fb; int sr; int mb; } exp_t;
    typedef struct { int dest; bit load; int edge_no; bit killed; } wr_t;

    exp_t expq[$];
    wr_t  writers[$];
    int   edge_cnt = 0;
    bit   m_busy = 0;
    int   m_reg = 0;
    int   passed = 0;
    int   total = 0;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] fn);
        return {op, rd, 15'd0, fn, 2'd0};
    endfunction

    function automatic void decode(input logic [31:0] ins, output int dest, output bit ld, output bit md);
        logic [4:0] op;
        op   = ins[31:27];
        dest = 0;
        if (op == 5'b00000 || op == 5'b00101 || op == 5'b01000) dest = int'(ins[26:22]);
        else if (op == 5'b00011) dest = JAL_REG;
        else if (op == 5'b10101) dest = SETX_REG;
        ld = (op == 5'b01000);
        md = (op == 5'b00000) && (ins[6:2] == 5'd6 || ins[6:2] == 5'd7);
    endfunction

    // Age of the youngest live writer of s (DEPTH when none): age k means stage k.
    function automatic int best_age(input int s);
        int best = DEPTH;
        foreach (writers[i]) begin
            if (!writers[i].killed && s != 0 && writers[i].dest == s &&
                edge_cnt - writers[i].edge_no < best)
                best = edge_cnt - writers[i].edge_no;
        end
        return best;
    endfunction

    function automatic bit md_hit(input int s);
        return m_busy && s != 0 && m_reg == s;
    endfunction

    function automatic exp_t compute_exp();
        exp_t e;
        int   ba, bb, d;
        bit   ld, md, lu;
        ba = best_age(int'(src_a));
        bb = best_age(int'(src_b));
        e.hz_a = (ba < DEPTH || md_hit(int'(src_a))) ? 1 : 0;
        e.hz_b = (bb < DEPTH || md_hit(int'(src_b))) ? 1 : 0;
        e.fa   = (ba < DEPTH) ? ba + 1 : 0;
        e.fb   = (bb < DEPTH) ? bb + 1 : 0;
        lu = 0;
        foreach (writers[i]) begin
            if (!writers[i].killed && writers[i].load && writers[i].edge_no == edge_cnt &&
                ((src_a != 0 && writers[i].dest == src_a) || (src_b != 0 && writers[i].dest == src_b)))
                lu = 1;
        end
        decode(instruction, d, ld, md);
        e.sr = (lu || md_hit(int'(src_a)) || md_hit(int'(src_b)) || (m_busy && issue_valid && md)) ? 1 : 0;
        e.mb = m_busy ? 1 : 0;
        return e;
    endfunction

    function automatic void model_clear();
        writers.delete();
        m_busy = 0;
        m_reg  = 0;
    endfunction

    function automatic void model_edge();
        int  d;
        bit  ld, md;
        wr_t w;
        edge_cnt++;
        if (flush) begin
            foreach (writers[i]) if (writers[i].edge_no == edge_cnt - 1) writers[i].killed = 1;
        end
        decode(instruction, d, ld, md);
        if (issue_valid && !stall && !flush && md) begin
            m_busy = 1;
            m_reg  = d;
        end else if (md_done) begin
            m_busy = 0;
        end
        if (issue_valid && !stall && !flush && d != 0 && !md) begin
            w.dest = d; w.load = ld; w.edge_no = edge_cnt; w.killed = 0;
            writers.push_back(w);
        end
        while (writers.size() > 0 && edge_cnt - writers[0].edge_no >= DEPTH)
            void'(writers.pop_front());
    endfunction

    task automatic cycle(input logic [31:0] ins, input bit iv, input bit st, input bit fl,
                         input bit md, input logic [4:0] sa, input logic [4:0] sb);
        instruction = ins; issue_valid = iv; stall = st; flush = fl; md_done = md;
        src_a = sa; src_b = sb;
        expq.push_back(compute_exp());
        @(posedge clock);
        if (reset) model_edge();
        #1;
    endtask

    task automatic mid_reset();
        reset = 1'b0;
        model_clear();
        #1;
        chk("async_rst_md_busy", int'(md_busy), 0);
        chk("async_rst_hazard_a", int'(hazard_a), 0);
        chk("async_rst_stall_req", int'(stall_req), 0);
        cycle(NOP, 1, 0, 0, 1, 5'd12, 5'd3);
        reset = 1'b1;
        cycle(NOP, 1, 0, 0, 1, 5'd12, 5'd0);
        cycle(NOP, 1, 0, 0, 0, 5'd12, 5'd0);
    endtask

    function automatic logic [4:0] pick_src();
        case ($urandom_range(0, 9))
            0:       return 5'd0;
            1:       return 5'd31;
            2:       return 5'd30;
            default: return 5'($urandom_range(1, 7));
        endcase
    endfunction

    initial begin
        forever begin
            @(negedge clock);
            if (expq.size() > 0) begin
                exp_t e;
                e = expq.pop_front();
                chk("hazard_a", int'(hazard_a), e.hz_a);
                chk("hazard_b", int'(hazard_b), e.hz_b);
                chk("fwd_a", int'(fwd_a), e.fa);
                chk("fwd_b", int'(fwd_b), e.fb);
                chk("stall_req", int'(stall_req), e.sr);
                chk("md_busy", int'(md_busy), e.mb);
            end
        end
    end

    initial begin
        reset = 1'b0;
        instruction = mk(5'b00000, 5'd5, 5'd6);
        issue_valid = 1'b1; stall = 1'b0; flush = 1'b0; md_done = 1'b0;
        src_a = 5'd5; src_b = 5'd7;
        #2;
        chk("reset_md_busy", int'(md_busy), 0);
        chk("reset_hazard_a", int'(hazard_a), 0);
        chk("reset_hazard_b", int'(hazard_b), 0);
        chk("reset_fwd_a", int'(fwd_a), 0);
        chk("reset_stall_req", int'(stall_req), 0);
        @(posedge clock);
        #1;
        cycle(mk(5'b00000, 5'd5, 5'd6), 1, 0, 0, 0, 5'd5, 5'd7);
        cycle(mk(5'b01000, 5'd7, 5'd0), 1, 0, 0, 1, 5'd7, 5'd7);
        reset = 1'b1;

        // addi r5 walks through all stages
        cycle(mk(5'b00101, 5'd5, 5'd0), 1, 0, 0, 0, 5'd0, 5'd0);
        for (int k = 0; k <= DEPTH; k++) cycle(NOP, 1, 0, 0, 0, 5'd5, 5'd0);
        // lw r7 load-use
        cycle(mk(5'b01000, 5'd7, 5'd0), 1, 0, 0, 0, 5'd0, 5'd0);
        cycle(NOP, 1, 1, 0, 0, 5'd0, 5'd7);
        cycle(NOP, 1, 0, 0, 0, 5'd0, 5'd7);
        // jal, setx, dest r0
        cycle(mk(5'b00011, 5'd0, 5'd0), 1, 0, 0, 0, 5'd0, 5'd0);
        cycle(mk(5'b10101, 5'd0, 5'd0), 1, 0, 0, 0, 5'd31, 5'd0);
        cycle(mk(5'b00101, 5'd0, 5'd0), 1, 0, 0, 0, 5'd30, 5'd31);
        cycle(NOP, 1, 0, 0, 0, 5'd0, 5'd0);
        // mul r9 until md_done, then md_done colliding with div r4
        cycle(mk(5'b00000, 5'd9, 5'd6), 1, 0, 0, 0, 5'd0, 5'd0);
        for (int k = 0; k < 3; k++) cycle(NOP, 1, 1, 0, 0, 5'd9, 5'd0);
        cycle(NOP, 1, 1, 0, 1, 5'd9, 5'd0);
        cycle(NOP, 1, 0, 0, 0, 5'd9, 5'd0);
        cycle(mk(5'b00000, 5'd9, 5'd7), 1, 0, 0, 0, 5'd0, 5'd0);
        cycle(mk(5'b00000, 5'd4, 5'd7), 1, 0, 0, 1, 5'd0, 5'd0);
        cycle(NOP, 1, 1, 0, 0, 5'd4, 5'd0);
        cycle(NOP, 1, 1, 0, 1, 5'd4, 5'd0);
        cycle(NOP, 1, 0, 0, 1, 5'd4, 5'd0);
        // md with dest r0, and a second md waiting in decode
        cycle(mk(5'b00000, 5'd0, 5'd6), 1, 0, 0, 0, 5'd0, 5'd0);
        cycle(mk(5'b00000, 5'd5, 5'd6), 1, 1, 0, 0, 5'd0, 5'd0);
        cycle(NOP, 1, 0, 0, 1, 5'd0, 5'd0);
        // lw r3 flushed out of stage 0; flush keeps an md pending
        cycle(mk(5'b01000, 5'd3, 5'd0), 1, 0, 0, 0, 5'd0, 5'd0);
        cycle(mk(5'b00000, 5'd12, 5'd6), 1, 0, 1, 0, 5'd3, 5'd0);
        cycle(NOP, 1, 0, 0, 0, 5'd3, 5'd0);
        cycle(mk(5'b00000, 5'd12, 5'd6), 1, 0, 0, 0, 5'd0, 5'd0);
        cycle(NOP, 1, 0, 1, 0, 5'd12, 5'd0);
        cycle(mk(5'b00101, 5'd3, 5'd0), 1, 0, 0, 0, 5'd12, 5'd0);
        mid_reset();

        for (int n = 0; n < 3000; n++) begin
            logic [4:0] op, rd, fn;
            case ($urandom_range(0, 6))
                0, 5:    op = 5'b00000;
                1:       op = 5'b00101;
                2:       op = 5'b01000;
                3:       op = 5'b00011;
                4:       op = 5'b10101;
                default: op = 5'($urandom);
            endcase
            rd = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            fn = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(6, 7)) : 5'($urandom);
            cycle(mk(op, rd, fn), $urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 6) == 0, pick_src(), pick_src());
            if (n % 700 == 350) mid_reset();
        end

        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
